// File: rtl/sub_seq_ctrl.sv
// Nibble-serial subtracter: one 4-bit ripple-borrow slice computes a - b - bin
// over NIB cycles, then holds the result until the consumer acknowledges it.
module sub_slice4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bi,
  output logic [3:0] d,
  output logic       bo
);
  logic [4:0] br;
  assign br[0] = bi;
  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign d[i]    = x[i] ^ y[i] ^ br[i];
    assign br[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br[i]);
  end
  assign bo = br[4];
endmodule

module sub_seq_ctrl #(
  parameter int NIB = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4*NIB-1:0] a,
  input  logic [4*NIB-1:0] b,
  input  logic             bin,
  input  logic             ack,
  output logic             busy,
  output logic             valid,
  output logic [4*NIB-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);
  localparam int W  = 4 * NIB;
  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  logic [IW-1:0] idx;
  logic [W-1:0]  a_r, b_r, diff_r, diff_nx;
  logic          brw, zero_r, ovf_r;
  logic [3:0]    sd;
  logic          sbo, last;

  assign last = (idx == IW'(NIB - 1));

  sub_slice4 u_slice (
    .x  (a_r[{idx, 2'b00} +: 4]),
    .y  (b_r[{idx, 2'b00} +: 4]),
    .bi (brw),
    .d  (sd),
    .bo (sbo)
  );

  // Full-width view of diff after this cycle's nibble lands; used for the flags.
  always_comb begin
    diff_nx = diff_r;
    diff_nx[{idx, 2'b00} +: 4] = sd;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    valid    = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        valid = 1'b1;
        if (ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      brw    <= 1'b0;
      diff_r <= '0;
      zero_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (state == IDLE && start) begin
      a_r <= a;
      b_r <= b;
      brw <= bin;
      idx <= '0;
    end else if (state == RUN) begin
      diff_r <= diff_nx;
      brw    <= sbo;
      idx    <= idx + IW'(1);
      // Flags are registered so they read 0 out of reset and stay put outside DONE.
      if (last) begin
        zero_r <= (diff_nx == '0);
        ovf_r  <= (a_r[W-1] ^ b_r[W-1]) & (diff_nx[W-1] ^ a_r[W-1]);
      end
    end
  end

  assign diff = diff_r;
  assign bout = brw;
  assign zero = zero_r;
  assign ovf  = ovf_r;
endmodule

// File: tb/tb_sub_seq_ctrl.sv
// Directed bench for sub_seq_ctrl: arithmetic reference model plus literal checks.
module tb_sub_seq_ctrl;
  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0, bin = 1'b0, ack = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, valid, bout, zero, ovf;
  logic [W-1:0] diff;

  int nvec = 0, nerr = 0, cyc = 0;

  sub_seq_ctrl #(.NIB(NIB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin), .ack(ack),
    .busy(busy), .valid(valid), .diff(diff), .bout(bout), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 computing (NIB cycles), 2 result held.
  int           m_phase = 0, m_cnt = 0;
  logic [W:0]   full;
  logic [W-1:0] p_diff = '0, e_diff = '0, ma = '0, mb = '0;
  logic         p_bout = 0, e_bout = 0, e_zero = 0, e_ovf = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; e_diff = '0; e_bout = 0; e_zero = 0; e_ovf = 0;
    end else begin
      case (m_phase)
        0: if (start) begin
          full   = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
          p_diff = full[W-1:0];
          p_bout = full[W];
          ma = a; mb = b;
          m_cnt = NIB; m_phase = 1;
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_phase = 2;
            e_diff = p_diff; e_bout = p_bout; e_zero = (p_diff == '0);
            e_ovf = (ma[W-1] ^ mb[W-1]) & (p_diff[W-1] ^ ma[W-1]);
          end
        end
        default: if (ack) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("m_busy", 32'(busy), 32'(m_phase == 1));
    chk("m_valid", 32'(valid), 32'(m_phase == 2));
    if (m_phase != 1) begin
      chk("m_diff", 32'(diff), 32'(e_diff));
      chk("m_bout", 32'(bout), 32'(e_bout));
      chk("m_zero", 32'(zero), 32'(e_zero));
      chk("m_ovf", 32'(ovf), 32'(e_ovf));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Start an op, scramble inputs after accept, count busy cycles up to valid.
  task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbin);
    start = 1; a = va; b = vb; bin = vbin;
    tick();
    start = 0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
  endtask

  task automatic wait_valid(output int nb);
    int i;
    nb = 0;
    for (i = 0; i < 20 && !valid; i++) begin
      if (busy) nb++;
      tick();
    end
    if (!valid) chk("valid_timeout", 32'(valid), 32'd1);
  endtask

  task automatic op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbin,
                    input logic [W-1:0] xd, input logic xb, input logic xz, input logic xo);
    int nb;
    launch(va, vb, vbin);
    wait_valid(nb);
    chk("busy_cycles", 32'(nb), 32'd4);
    chk("diff", 32'(diff), 32'(xd));
    chk("bout", 32'(bout), 32'(xb));
    chk("zero", 32'(zero), 32'(xz));
    chk("ovf", 32'(ovf), 32'(xo));
    ack = 1;
    tick();
    ack = 0;
    chk("valid_fall", 32'(valid), 32'd0);
    chk("diff_retained", 32'(diff), 32'(xd));
  endtask

  initial begin
    int nb, t0;
    #1 rst_n = 0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_flags", 32'({bout, zero, ovf}), 32'd0);
    rst_n = 1;

    op(16'h1234, 16'h0234, 0, 16'h1000, 0, 0, 0);
    op(16'h0000, 16'h0001, 0, 16'hFFFF, 1, 0, 0);
    op(16'h0005, 16'h0005, 1, 16'hFFFF, 1, 0, 0);
    op(16'h8000, 16'h0001, 0, 16'h7FFF, 0, 0, 1);
    op(16'h4321, 16'h4321, 0, 16'h0000, 0, 1, 0);
    op(16'h7FFF, 16'hFFFF, 0, 16'h8000, 1, 0, 1);
    op(16'hFFFF, 16'h0000, 1, 16'hFFFE, 0, 0, 0);

    // start during RUN and DONE must be ignored
    launch(16'h1234, 16'h0234, 0);
    tick();
    start = 1; a = 16'hFFFF; b = 16'h0001; bin = 1;
    tick();
    start = 0;
    wait_valid(nb);
    for (int i = 0; i < 5; i++) begin
      start = i[0]; a = 16'h0F0F; b = 16'h00FF;
      chk("hold_valid", 32'(valid), 32'd1);
      chk("hold_diff", 32'(diff), 32'h1000);
      tick();
    end
    start = 1; ack = 1;
    tick();
    start = 0; ack = 0;
    chk("ack_idle_valid", 32'(valid), 32'd0);
    chk("ack_idle_busy", 32'(busy), 32'd0);
    tick();
    chk("no_queued_op", 32'(busy), 32'd0);

    // asynchronous reset in RUN cycle 2
    launch(16'h8000, 16'h0001, 0);
    tick();
    #2 rst_n = 0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_diff", 32'(diff), 32'd0);
    chk("arst_bout", 32'(bout), 32'd0);
    tick();
    rst_n = 1;
    op(16'h1234, 16'h0234, 0, 16'h1000, 0, 0, 0);

    // back-to-back: ack in first DONE cycle, start in the next IDLE cycle
    launch(16'h0000, 16'h0001, 0);
    wait_valid(nb);
    t0 = cyc;
    ack = 1;
    tick();
    ack = 0;
    launch(16'h4321, 16'h4321, 0);
    wait_valid(nb);
    chk("b2b_latency", 32'(cyc - t0), 32'(NIB + 2));
    chk("b2b_zero", 32'(zero), 32'd1);
    ack = 1;
    tick();
    ack = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
